id_ex_skid: RTL and testbench
=============================

# id_ex_skid

Decode-to-execute pipeline register for the RV32I core, with skid buffering. It captures the decoded instruction bundle (PC, operands, 4-bit ALU opcode, destination register, write enable) from the decode stage. It presents the bundle to the execute stage, where `out_alu_op` drives the ALU decoder directly. A two-entry valid/ready skid buffer gives full throughput, breaks the combinational ready path, and supports a synchronous flush for branch redirects.

## Interface
Parameters:
- `XLEN`, 32: datapath width of PC and operands.
- `OPW`, 4: ALU opcode width; encodings are the `param.v` macros (`add`, `sub`, `logic_and`, ...).

Ports:
- `clk`  in  1  system clock, rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous kill of all buffered entries.
- `in_valid`  in  1  decode bundle valid.
- `in_ready`  out  1  stage can accept a bundle; registered.
- `in_pc`  in  XLEN  instruction PC.
- `in_a`  in  XLEN  ALU operand A.
- `in_b`  in  XLEN  ALU operand B (rs2 or immediate, already selected).
- `in_alu_op`  in  OPW  ALU opcode.
- `in_rd`  in  5  destination register index.
- `in_reg_we`  in  1  register write enable.
- `out_valid`  out  1  execute bundle valid.
- `out_ready`  in  1  execute stage consumes the bundle.
- `out_pc`, `out_a`, `out_b`, `out_alu_op`, `out_rd`  out  as input  registered bundle.
- `out_reg_we`  out  1  registered `in_reg_we` AND `out_valid`.

## Operation
Storage:
- Main register M drives all `out_*` signals.
- Skid register S holds one overflow bundle.
- Payload width is 3·XLEN+OPW+6 = 106 bits.

Accept and consume:
- Input accept: `in_fire = in_valid & in_ready`.
- Output consume: `out_fire = out_valid & out_ready`.

States and status outputs:
- EMPTY: M invalid, S invalid; `out_valid`=0, `in_ready`=1.
- HALF: M valid, S invalid; `out_valid`=1, `in_ready`=1.
- FULL: M valid, S valid; `out_valid`=1, `in_ready`=0.

Transitions (when `flush`=0):
- EMPTY: `in_fire` → HALF, M←in. Otherwise stay.
- HALF: `in_fire & out_fire` → HALF, M←in.
- HALF: `in_fire & !out_fire` → FULL, S←in, M unchanged.
- HALF: `!in_fire & out_fire` → EMPTY.
- HALF: neither → stay.
- FULL: `out_fire` → HALF, M←S. Otherwise stay. No accept is possible in FULL.

Flush:
- `flush`=1 forces next state EMPTY regardless of every other input.
- A bundle presented with `in_fire` in the flush cycle is dropped.
- Payload flops are not cleared by flush; only the valid state is cleared.

General rules:
- Ordering is strictly FIFO; a bundle is never duplicated or reordered.
- M is held stable while `out_valid & !out_ready`.
- `out_reg_we` is forced to 0 whenever `out_valid`=0, so bubbles never write the register file.
- Nothing is computed on the payload; widths pass through unchanged.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - state EMPTY, so `out_valid`=0 and `in_ready`=1.
  - `out_pc`, `out_a`, `out_b` = 0; `out_rd`=0; `out_reg_we`=0.
  - `out_alu_op` = `add.
  - S payload = 0.
- Reset deassertion takes effect on the next rising edge with normal behaviour.
- Latency: a bundle accepted at edge N appears on `out_*` with `out_valid`=1 after edge N.
- Throughput: 1 bundle/cycle while `out_ready`=1.
- `in_ready` is a flop output (state≠FULL), with no combinational path from `out_ready`.
  - Because of this, when `out_ready` drops, a second bundle can be accepted into S.
- `out_valid` and all `out_*` come directly from flops.
- Reset mid-operation discards M and S immediately, without waiting for a clock edge.

## Test plan
- Reset: hold `rst_n`=0 with `in_valid`=1 → `out_valid`=0, `in_ready`=1, `out_alu_op`=`add; nothing is accepted until the first edge after release.
- Streaming: 8 back-to-back bundles with `in_pc`=0x100+4k and `out_ready`=1 → `out_pc` is 0x100..0x11C on consecutive cycles, 1-cycle latency, `in_ready` stays 1.
- Backpressure: `out_ready`=0 while A, B arrive → state FULL, `in_ready`=0 on the following cycle, `out_pc` held at A; raise `out_ready` → A then B in order, no loss.
- Flush while FULL, with `in_valid`=1 in the same cycle → next cycle `out_valid`=0, `out_reg_we`=0, `in_ready`=1; the flushed-cycle bundle never appears.
- Bubble gating: `in_reg_we`=1 with `in_valid`=0 → `out_reg_we` stays 0.
- Random: 10k cycles of random `in_valid`, `out_ready` and `flush` at 2% → scoreboard matches in-order delivery minus flushed entries, and `out_*` is stable whenever `out_valid & !out_ready`.

Source files
------------

// File: rtl/id_ex_skid.sv
// id_ex_skid: decode-to-execute pipeline register with a two-entry skid buffer.
// Registered in_ready and out_*, strict FIFO order, synchronous flush.
//
// Ports:
//   clk, rst_n         rising-edge clock, async active-low reset
//   flush              kill all buffered bundles (sync)
//   in_valid/in_ready  decode-side handshake; in_ready is a flop
//   in_pc,in_a,in_b    PC and ALU operands (XLEN)
//   in_alu_op          ALU opcode (OPW)
//   in_rd,in_reg_we    destination register and write enable
//   out_valid/ready    execute-side handshake
//   out_*              main register M; out_reg_we gated by out_valid
module id_ex_skid #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned OPW  = 4,
  parameter logic [OPW-1:0] ADD_OP = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [OPW-1:0]  in_alu_op,
  input  logic [4:0]      in_rd,
  input  logic            in_reg_we,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [OPW-1:0]  out_alu_op,
  output logic [4:0]      out_rd,
  output logic            out_reg_we
);

  localparam int unsigned PW = 3*XLEN + OPW + 6;

  localparam logic [PW-1:0] M_RST =
    {{(3*XLEN){1'b0}}, ADD_OP, 6'b0};

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic [PW-1:0] m_q, m_d;
  logic [PW-1:0] s_q, s_d;

  logic [PW-1:0] in_bus;
  logic          in_fire;
  logic          out_fire;
  logic          m_we;

  assign in_bus = {in_pc, in_a, in_b,
                   in_alu_op, in_rd, in_reg_we};

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d = HALF;
          m_d     = in_bus;
        end
      end
      HALF: begin
        if (in_fire && out_fire) begin
          m_d = in_bus;
        end else if (in_fire) begin
          state_d = FULL;
          s_d     = in_bus;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          state_d = HALF;
          m_d     = s_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    // A flush drops everything, including a bundle
    // fired this cycle; payload flops are left alone.
    if (flush) begin
      state_d = EMPTY;
      m_d     = m_q;
      s_d     = s_q;
    end
    in_ready_d  = (state_d != FULL);
    out_valid_d = (state_d != EMPTY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      m_q         <= M_RST;
      s_q         <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      m_q         <= m_d;
      s_q         <= s_d;
    end
  end

  assign {out_pc, out_a, out_b,
          out_alu_op, out_rd, m_we} = m_q;

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_reg_we = m_we & out_valid_q;

endmodule

// File: tb/tb_id_ex_skid.sv
// tb_id_ex_skid: table vectors, directed sequences and a
// FIFO scoreboard for the id_ex_skid pipeline register.
module tb_id_ex_skid;

  localparam logic [3:0] ADD_OP = 4'h0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc, in_a, in_b;
  logic [3:0]  in_alu_op;
  logic [4:0]  in_rd;
  logic        in_reg_we;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc, out_a, out_b;
  logic [3:0]  out_alu_op;
  logic [4:0]  out_rd;
  logic        out_reg_we;

  always #5 clk = ~clk;

  id_ex_skid #(.XLEN(32), .OPW(4), .ADD_OP(ADD_OP)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_a(in_a), .in_b(in_b),
    .in_alu_op(in_alu_op), .in_rd(in_rd),
    .in_reg_we(in_reg_we),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_a(out_a), .out_b(out_b),
    .out_alu_op(out_alu_op), .out_rd(out_rd),
    .out_reg_we(out_reg_we)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        we;
  } bundle_t;

  typedef struct {
    logic        fl;
    logic        iv;
    logic        ordy;
    logic [31:0] pc;
    logic        we;
    logic        chk_pc;
    logic        ov;
    logic        ir;
    logic [31:0] epc;
    logic        ewe;
  } vec_t;

  bundle_t q[$];
  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;

  function automatic void chk(string name,
                              logic [31:0] act,
                              logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got 0x%0h, want 0x%0h @%0t",
                 name, act, exp, $time);
    end
  endfunction

  function automatic bundle_t mk(logic [31:0] pc, logic we);
    bundle_t b;
    b.pc = pc;
    b.a  = pc ^ 32'hA5A5_0000;
    b.b  = ~pc;
    b.op = pc[5:2];
    b.rd = pc[6:2];
    b.we = we;
    return b;
  endfunction

  function automatic bundle_t rnd();
    bundle_t b;
    b.pc = $urandom;
    b.a  = $urandom;
    b.b  = $urandom;
    b.op = 4'($urandom);
    b.rd = 5'($urandom);
    b.we = 1'($urandom);
    return b;
  endfunction

  // Compare the DUT against the model state at a negedge.
  task automatic sb_check();
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
    if (q.size() > 0) begin
      chk("out_pc", out_pc, q[0].pc);
      chk("out_a", out_a, q[0].a);
      chk("out_b", out_b, q[0].b);
      chk("out_alu_op", 32'(out_alu_op), 32'(q[0].op));
      chk("out_rd", 32'(out_rd), 32'(q[0].rd));
      chk("out_reg_we", 32'(out_reg_we), 32'(q[0].we));
    end else begin
      chk("bubble_we", 32'(out_reg_we), 32'b0);
    end
  endtask

  // Drive one cycle from a negedge, update the model for the
  // coming posedge, then check at the following negedge.
  task automatic step(logic fl, logic iv, logic ordy,
                      bundle_t b);
    bit room;
    flush     = fl;
    in_valid  = iv;
    out_ready = ordy;
    in_pc     = b.pc;
    in_a      = b.a;
    in_b      = b.b;
    in_alu_op = b.op;
    in_rd     = b.rd;
    in_reg_we = b.we;
    room = (q.size() < 2);
    if (ordy && q.size() > 0) void'(q.pop_front());
    if (iv && room && !fl) q.push_back(b);
    if (fl) q.delete();
    @(negedge clk);
    sb_check();
  endtask

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{0,1,0,32'h200,1, 1, 1,1,32'h200,1};
    vecs[1]  = '{0,1,0,32'h204,0, 1, 1,0,32'h200,1};
    vecs[2]  = '{0,1,0,32'h208,1, 1, 1,0,32'h200,1};
    vecs[3]  = '{0,0,1,32'h20C,1, 1, 1,1,32'h204,0};
    vecs[4]  = '{0,0,1,32'h210,1, 1, 0,1,32'h204,0};
    vecs[5]  = '{0,1,0,32'h300,1, 1, 1,1,32'h300,1};
    vecs[6]  = '{0,1,0,32'h304,1, 1, 1,0,32'h300,1};
    vecs[7]  = '{1,1,0,32'h308,1, 1, 0,1,32'h300,0};
    vecs[8]  = '{0,0,1,32'h30C,1, 1, 0,1,32'h300,0};
    vecs[9]  = '{1,1,1,32'h400,1, 0, 0,1,32'h0,0};
    vecs[10] = '{0,1,1,32'h500,1, 1, 1,1,32'h500,1};
    vecs[11] = '{0,1,1,32'h504,0, 1, 1,1,32'h504,0};
    vecs[12] = '{0,0,1,32'h508,1, 0, 0,1,32'h0,0};

    // Reset held with in_valid asserted.
    rst_n = 1'b0;
    flush = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b0;
    in_pc = 32'h80;
    in_a = 32'h1;
    in_b = 32'h2;
    in_alu_op = 4'h7;
    in_rd = 5'd3;
    in_reg_we = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'b0);
    chk("rst_in_ready", 32'(in_ready), 32'b1);
    chk("rst_alu_op", 32'(out_alu_op), 32'(ADD_OP));
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_a", out_a, 32'h0);
    chk("rst_rd", 32'(out_rd), 32'h0);
    chk("rst_we", 32'(out_reg_we), 32'h0);

    // First edge after release accepts the bundle.
    rst_n = 1'b1;
    step(0, 1, 0, mk(32'h80, 1));
    chk("rel_pc", out_pc, 32'h80);
    step(0, 0, 1, mk(32'h84, 0));

    // Streaming: one bundle per cycle, 1-cycle latency.
    for (int k = 0; k < 8; k++) begin
      step(0, 1, 1, mk(32'h100 + 32'(4*k), 1));
      chk("stream_pc", out_pc, 32'h100 + 32'(4*k));
      chk("stream_rdy", 32'(in_ready), 32'b1);
    end
    step(0, 0, 1, mk(32'h0, 0));

    // Table: backpressure, flush while FULL, bubbles.
    for (int i = 0; i < 13; i++) begin
      step(vecs[i].fl, vecs[i].iv, vecs[i].ordy,
           mk(vecs[i].pc, vecs[i].we));
      chk("vec_ov", 32'(out_valid), 32'(vecs[i].ov));
      chk("vec_ir", 32'(in_ready), 32'(vecs[i].ir));
      chk("vec_we", 32'(out_reg_we), 32'(vecs[i].ewe));
      if (vecs[i].chk_pc)
        chk("vec_pc", out_pc, vecs[i].epc);
    end

    // Random traffic with occasional flush.
    for (int c = 0; c < 10000; c++) begin
      step(1'($urandom_range(0, 49) == 0),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) != 0),
           rnd());
    end

    // Asynchronous reset in the middle of a FULL buffer.
    step(0, 1, 0, mk(32'h600, 1));
    step(0, 1, 0, mk(32'h604, 1));
    chk("pre_arst_full", 32'(in_ready), 32'b0);
    #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("arst_ov", 32'(out_valid), 32'b0);
    chk("arst_ir", 32'(in_ready), 32'b1);
    chk("arst_pc", out_pc, 32'h0);
    chk("arst_op", 32'(out_alu_op), 32'(ADD_OP));
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 1, mk(32'h700, 1));
    step(0, 1, 1, mk(32'h704, 1));
    step(0, 0, 1, mk(32'h708, 0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
